// File: rtl/serial_adder_if.sv
// serial_adder_if
// Groups the request/result signals of the bit-serial adder.
//   start      : request; the adder samples it only while idle
//   a, b, cin  : operands; captured on the edge that accepts start
//   busy       : high while an addition is in progress
//   done       : one-cycle completion pulse
//   sum, cout  : result registers, holding the last completed result
//   state_dbg  : current FSM state (0 = IDLE, 1 = SHIFT), for observation
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0; start while busy=1 is ignored. Completion is signalled by a
// single-cycle done pulse, with sum/cout valid from that edge onward.
// master = requester side, slave = adder side.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             state_dbg;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, state_dbg
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, state_dbg
   );
endinterface

// File: rtl/serial_adder.sv
// full_adder
// One-bit full adder cell.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry-out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// serial_adder
// Bit-serial adder for two WIDTH-bit operands built around one full_adder
// cell. Operands are shifted through the cell LSB first, one bit pair per
// clock, with the carry held in a flop between bits. A result is produced
// WIDTH cycles after the accepting edge.
//   clk   : system clock, rising-edge
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if slave port (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   acc_sr_q, acc_sr_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;

   logic               fa_sum;
   logic               fa_cout;

   full_adder u_full_adder (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      acc_sr_d = acc_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sum_d    = sum_q;
      cout_d   = cout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Accumulator fills from the MSB so that after WIDTH shifts the
            // first (least significant) sum bit has reached bit 0.
            acc_sr_d = {fa_sum, acc_sr_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               // Publish the accumulator including the bit formed this cycle.
               sum_d   = {fa_sum, acc_sr_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         acc_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         acc_sr_q <= acc_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed test of serial_adder (WIDTH=8). Inputs are driven just after the
// falling edge and outputs are sampled on the falling edge. A monitor pops
// the expected {cout,sum} queue on every done pulse; a done with nothing
// expected is reported as spurious.
module tb_serial_adder;
   localparam int WIDTH = 8;
   localparam int RW    = WIDTH + 1;

   logic clk;
   logic rst_n;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int done_seen = 0;

   logic [RW-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && bus.done === 1'b1) begin
         done_seen++;
         if (exp_q.size() == 0)
            check_val("spurious_done", 32'(bus.done), 32'd0);
         else
            check_val("result", 32'({bus.cout, bus.sum}), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
   endtask

   // Present a request just after a falling edge; returns just after the
   // accepting edge k (at the next falling edge) with start dropped and the
   // operand inputs scrambled to show they no longer matter.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [RW-1:0] exp);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      exp_q.push_back(exp);
      step();
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom_range(0, 255));
      bus.b     = WIDTH'($urandom_range(0, 255));
      bus.cin   = 1'($urandom_range(0, 1));
   endtask

   // Full operation with cycle-exact busy/done checks.
   task automatic run_checked(input string tag, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic cin,
                              input logic [RW-1:0] exp);
      int busy_cycles;
      int done_cnt;
      issue(a, b, cin, exp);
      busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
      done_cnt    = (bus.done === 1'b1) ? 1 : 0;
      for (int j = 1; j <= WIDTH; j++) begin
         step();
         if (j < WIDTH) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) done_cnt++;
         end
      end
      check_val({tag, "_done_at_k+W"}, 32'(bus.done), 32'd1);
      check_val({tag, "_busy_at_k+W"}, 32'(bus.busy), 32'd0);
      check_val({tag, "_sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
      check_val({tag, "_cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
      check_val({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
      check_val({tag, "_early_done"}, 32'(done_cnt), 32'd0);
      step();
      check_val({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
      check_val({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int seen_before;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      step();
      step();
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_sum", 32'(bus.sum), 32'd0);
      check_val("rst_cout", 32'(bus.cout), 32'd0);
      check_val("rst_state", 32'(bus.state_dbg), 32'd0);
      rst_n = 1'b1;
      step();
      check_val("idle_no_done", 32'(bus.done), 32'd0);

      // FF + 01 + 0 = 0x100 (full carry ripple)
      run_checked("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
      // 00 + 00 + 1 = 0x001
      run_checked("cin", 8'h00, 8'h00, 1'b1, 9'h001);
      // A5 + 5A + 1 = FF + 1 = 0x100
      run_checked("mixed", 8'hA5, 8'h5A, 1'b1, 9'h100);
      // 3C + 0F + 0 = 0x04B
      run_checked("plain", 8'h3C, 8'h0F, 1'b0, 9'h04B);

      // Busy rejection: a second start at k+3 must be ignored.
      seen_before = done_seen;
      issue(8'h03, 8'h04, 1'b0, 9'h007);          // now after edge k
      step();                                       // after k+1
      step();                                       // after k+2
      bus.start = 1'b1;
      bus.a     = 8'hFF;
      bus.b     = 8'hFF;
      bus.cin   = 1'b1;
      step();                                       // edge k+3 sampled start
      bus.start = 1'b0;
      check_val("rej_busy_k+3", 32'(bus.busy), 32'd1);
      for (int j = 4; j <= WIDTH; j++) step();      // after k+8
      check_val("rej_done_k+8", 32'(bus.done), 32'd1);
      check_val("rej_sum", 32'(bus.sum), 32'h07);
      for (int j = 0; j < 12; j++) step();
      check_val("rej_single_done", 32'(done_seen - seen_before), 32'd1);
      check_val("rej_idle", 32'(bus.busy), 32'd0);

      // Reset mid-operation at edge k+4.
      seen_before = done_seen;
      issue(8'h10, 8'h20, 1'b0, 9'h030);            // after edge k
      step();
      step();
      step();                                       // after k+3
      rst_n = 1'b0;
      step();                                       // edge k+4 in reset
      exp_q.delete();
      rst_n = 1'b1;
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_val("mid_rst_done", 32'(bus.done), 32'd0);
      check_val("mid_rst_sum", 32'(bus.sum), 32'd0);
      check_val("mid_rst_cout", 32'(bus.cout), 32'd0);
      for (int j = 0; j < 10; j++) step();
      check_val("mid_rst_no_done", 32'(done_seen - seen_before), 32'd0);
      run_checked("after_rst", 8'h01, 8'h01, 1'b0, 9'h002);

      // Back-to-back: second start presented on the done cycle.
      issue(8'h03, 8'h04, 1'b0, 9'h007);            // after edge k
      for (int j = 1; j <= WIDTH; j++) step();      // after k+8
      check_val("b2b_done1", 32'(bus.done), 32'd1);
      check_val("b2b_sum1", 32'(bus.sum), 32'h07);
      check_val("b2b_idle_on_done", 32'(bus.state_dbg), 32'd0);
      issue(8'h10, 8'h20, 1'b0, 9'h030);            // accepted at k+9
      check_val("b2b_busy_k+9", 32'(bus.busy), 32'd1);
      for (int j = 10; j <= 16; j++) begin
         step();
         check_val("b2b_sum_hold", 32'(bus.sum), 32'h07);
         check_val("b2b_no_done", 32'(bus.done), 32'd0);
      end
      step();                                       // after k+17
      check_val("b2b_done2", 32'(bus.done), 32'd1);
      check_val("b2b_sum2", 32'(bus.sum), 32'h30);
      step();
      step();

      check_val("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder for two `WIDTH`-bit operands. It is built around a single `full_adder` instance, with a registered carry and operand shift registers. It sits directly downstream of the structural `full_adder`: it feeds that cell one bit pair per clock and consumes its `sum`/`cout` to assemble a full-width result. It trades `WIDTH` cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2–32.

- `clk`  input  1  system clock; all state updates on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `start`  input  1  request; sampled only while idle
- `a`  input  WIDTH  operand A; captured on accepted `start`
- `b`  input  WIDTH  operand B; captured on accepted `start`
- `cin`  input  1  carry-in; captured on accepted `start`
- `busy`  output  1  high while an addition is in progress
- `done`  output  1  one-cycle completion pulse
- `sum`  output  WIDTH  result register; holds last completed result
- `cout`  output  1  carry-out of last completed result

## Operation
- Two states: IDLE and SHIFT.
- IDLE, `start`=1 at edge k:
  - `a`→`a_sr`, `b`→`b_sr`, `cin`→`carry`.
  - `cnt`←0, `busy`←1, state←SHIFT.
- IDLE, `start`=0: nothing changes.
- SHIFT, each edge:
  - The `full_adder` instance sees `a_sr[0]`, `b_sr[0]`, `carry`.
  - Its `sum` is shifted into `acc_sr` at the MSB (`acc_sr` shifts right).
  - Its `cout`→`carry`.
  - `a_sr` and `b_sr` shift right; `cnt`++.
- SHIFT, edge where `cnt`==WIDTH-1 (the WIDTH-th bit):
  - The final `acc_sr` value (including this bit) →`sum`.
  - Adder `cout`→`cout`.
  - `done`←1, `busy`←0, state←IDLE.
- `done` is cleared on every edge where it is not being set. It is never high for more than one cycle per operation.
- `start` while `busy`=1 is ignored. Operands, `cin` and the in-flight result are unaffected.
- `sum`/`cout` change only on the completion edge. They hold across IDLE and during a following operation.
- Result equals `{cout,sum}` = `a`+`b`+`cin` as a (WIDTH+1)-bit unsigned value. No overflow flag.
- `cnt` width: enough bits to hold WIDTH-1.

## Timing
- Reset: when `rst_n`=0 at an edge, state←IDLE and everything below clears to 0:
  - outputs `busy`, `done`, `sum`, `cout`;
  - internal `a_sr`, `b_sr`, `acc_sr`, `carry`, `cnt`.
- Reset mid-operation aborts it with no `done` pulse; `sum`/`cout` read 0.
- Reset has priority over `start`.
- Latency, `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+WIDTH.
  - `done`=1 and new `sum`/`cout` valid from edge k+WIDTH until edge k+WIDTH+1.
- Back-to-back: state is IDLE while `done`=1. A `start` sampled at edge k+WIDTH+1 is accepted, giving a throughput of one result per WIDTH+1 cycles.
- `start` held high continuously restarts on every IDLE cycle; each run uses the operands present on its accepting edge.
- Operand inputs may change freely while `busy`=1 without affecting the result.

## Test plan
- After reset with `rst_n`=0 for 2 cycles: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Carry ripple, WIDTH=8: `a`=8'hFF, `b`=8'h01, `cin`=0, start at edge k.
  - `done` pulses exactly at edge k+8 with `sum`=8'h00, `cout`=1.
  - `busy` is high for exactly 8 cycles.
- Carry-in, WIDTH=8: `a`=0, `b`=0, `cin`=1 → `sum`=8'h01, `cout`=0.
- Mixed values, WIDTH=8: `a`=8'hA5, `b`=8'h5A, `cin`=1 → `sum`=8'h00, `cout`=1.
- Busy rejection: start 8'h03+8'h04, then pulse `start` with `a`=8'hFF at edge k+3.
  - Result is still 8'h07 at k+8.
  - No second `done` follows.
- Reset mid-operation: start 8'h10+8'h20, drive `rst_n`=0 at edge k+4.
  - No `done`; `sum`=0, `busy`=0.
  - A new start 8'h01+8'h01 afterwards yields 8'h02.
- Back-to-back: start asserted on the `done` cycle.
  - Second operation is accepted at k+9; second `done` at k+17.
  - First result (8'h07) holds on `sum` until k+17.
